prefetch_axi_responder: RTL and testbench
=========================================

# prefetch_axi_responder

AXI4 subordinate that terminates the single-beat, 64-byte read and write traffic issued by the prefetch initiator. It backs a small line-addressed on-chip buffer and returns R and B responses with a configurable read latency. It sits at the device side of the prefetch AXI4-MM link, as a memory target for integration and as a bench model.

## Interface
- `BASE_ADDR`, default 64'h0: byte address of line 0.
- `DEPTH_LINES`, default 64: number of 512-bit lines; must be a power of 2, at least 2.
- `READ_LAT`, default 2: cycles from AR handshake to `rvalid`; range 1..15.
- `axi4_mm_clk`  in  1  sole clock.
- `axi4_mm_rst`  in  1  synchronous, active-high reset.
- `arid` in 12, `araddr` in 64, `arlen` in 10, `arsize` in 3, `arburst` in 2, `aruser` in 6, `arvalid` in 1: read address; `aruser` is ignored.
- `arready`  out  1.
- `rid` out 12, `rdata` out 512, `rresp` out 2, `rlast` out 1, `ruser` out 1, `rvalid` out 1; `rready` in 1.
- `awid` in 12, `awaddr` in 64, `awlen` in 10, `awsize` in 3, `awuser` in 6, `awvalid` in 1: write address; `awuser` is ignored.
- `awready`  out  1.
- `wdata` in 512, `wstrb` in 64, `wlast` in 1, `wvalid` in 1; `wready` out 1.
- `bid` out 12, `bresp` out 2, `buser` out 4, `bvalid` out 1; `bready` in 1.
- `stat_rd_cnt`, `stat_wr_cnt`, `stat_err_cnt`  out  32 each: see Configuration.

## Operation
- Index = (addr − `BASE_ADDR`) >> 6. The low 6 address bits are ignored, so the address aligns down.
- A request is legal when `BASE_ADDR` ≤ addr < `BASE_ADDR` + 64·`DEPTH_LINES`, len = 0 and size = 3'b110. Any other request is an error.
- Read FSM:
  - `RD_IDLE`: `arready`=1. On AR handshake, latch the id and legality, sample the addressed line, and go to `RD_WAIT` (or directly to `RD_RESP` when `READ_LAT`=1).
  - `RD_WAIT`: count down `READ_LAT`−1 cycles, then go to `RD_RESP`.
  - `RD_RESP`: `rvalid`=1, `rlast`=1, `rid` = latched id. Legal: `rresp`=2'b00 and `rdata` = sampled line. Error: `rresp`=2'b10 and `rdata`=0. On `rready`, go to `RD_IDLE`.
- Write FSM:
  - `WR_IDLE`: `awready`=1 until an AW is latched; `wready`=1 until a W is latched. AW and W are accepted independently, in either order or in the same cycle.
  - In the cycle both are held (latched or live handshake), a legal write updates the line bytewise under `wstrb`. An error write changes nothing. Then go to `WR_RESP`.
  - `WR_RESP`: `bvalid`=1, `bid` = AW id, `bresp` = 2'b00 or 2'b10. `awready`=`wready`=0. On `bready`, clear both latches and go to `WR_IDLE`.
- `wlast` is ignored. `ruser`=0 and `buser`=0 always.
- Read and write paths are fully independent; one outstanding transaction per direction.
- Same-line collision: when the AR sample and the write commit fall in the same cycle, the read returns the pre-write data (read-before-write).
- Line contents are not reset.

## Timing
- Reset values: `arready`=0, `awready`=0, `wready`=0, `rvalid`=0, `bvalid`=0. `rid`, `rdata`, `rresp`, `bid` and `bresp` are 0. Counters are 0. Both FSMs are idle.
- Ready outputs rise in the first cycle after reset deasserts.
- AR handshake at cycle t → `rvalid` at t+`READ_LAT`. All R outputs hold stable until `rready`. `arready` returns at handshake+1.
- Write completion at cycle t → `bvalid` at t+1. B outputs hold until `bready`.
- Reset asserted mid-transaction: every pending transaction is discarded, all valids are 0 from the next cycle, and no memory write occurs in the reset cycle.

## Configuration
- `PREFETCH_RESP_STATS_EN` defined:
  - `stat_rd_cnt` increments on each R handshake.
  - `stat_wr_cnt` increments on each B handshake.
  - `stat_err_cnt` increments on each R or B handshake carrying 2'b10; a same-cycle R and B error adds 2.
  - All counters wrap at 2^32 and clear on reset.
- `PREFETCH_RESP_STATS_EN` undefined: all three counters are tied to 0 and no counter logic is compiled.

## Test plan
- Write `awaddr`=`BASE_ADDR`+0x40, `wdata`=pattern A, `wstrb`=all-ones, then read the same address → `rdata`=A, `rresp`=0, `rvalid` exactly `READ_LAT` cycles after AR.
- W presented 3 cycles before AW with `wstrb`=64'h00000000_0000FFFF over a line holding A → `bresp`=0 one cycle after AW accept; readback shows bytes 0-15 new and the rest A.
- `araddr`=`BASE_ADDR`+64·`DEPTH_LINES` → `rresp`=2'b10, `rdata`=0. `arsize`=3'b101 at a legal address → `rresp`=2'b10. An error write leaves the line unchanged.
- AR and write commit to the same line in the same cycle (old B, new C) → read returns B; a subsequent read returns C.
- Hold `rready`=0 and `bready`=0 for 10 cycles → `rvalid`, `bvalid` and payloads stay stable; no new AR/AW/W accepted meanwhile.
- Assert `axi4_mm_rst` while in `RD_WAIT` and `WR_RESP` → no `rvalid` and no `bvalid` afterwards. With `PREFETCH_RESP_STATS_EN` defined, counters read 0 after reset, then 1/1/0 after one good read and one good write.

Source files
------------

// File: rtl/prefetch_axi_responder.sv
// AXI4 subordinate backing a line-addressed buffer for single-beat 64-byte prefetch traffic.
// Define PREFETCH_RESP_STATS_EN to build the R/B handshake and error counters.
module prefetch_axi_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          DEPTH_LINES = 64,
  parameter int          READ_LAT    = 2
) (
  input  logic          axi4_mm_clk,
  input  logic          axi4_mm_rst,
  input  logic [11:0]   arid,
  input  logic [63:0]   araddr,
  input  logic [9:0]    arlen,
  input  logic [2:0]    arsize,
  input  logic [1:0]    arburst,
  input  logic [5:0]    aruser,
  input  logic          arvalid,
  output logic          arready,
  output logic [11:0]   rid,
  output logic [511:0]  rdata,
  output logic [1:0]    rresp,
  output logic          rlast,
  output logic          ruser,
  output logic          rvalid,
  input  logic          rready,
  input  logic [11:0]   awid,
  input  logic [63:0]   awaddr,
  input  logic [9:0]    awlen,
  input  logic [2:0]    awsize,
  input  logic [5:0]    awuser,
  input  logic          awvalid,
  output logic          awready,
  input  logic [511:0]  wdata,
  input  logic [63:0]   wstrb,
  input  logic          wlast,
  input  logic          wvalid,
  output logic          wready,
  output logic [11:0]   bid,
  output logic [1:0]    bresp,
  output logic [3:0]    buser,
  output logic          bvalid,
  input  logic          bready,
  output logic [31:0]   stat_rd_cnt,
  output logic [31:0]   stat_wr_cnt,
  output logic [31:0]   stat_err_cnt
);
  localparam int          IW   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH_LINES) << 6;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic       {WR_IDLE, WR_RESP} wr_state_t;

  // diff carries a borrow bit so addresses below BASE_ADDR are rejected
  function automatic logic legal_req(input logic [64:0] diff, input logic [9:0] len,
                                     input logic [2:0] size);
    return !diff[64] && (diff[63:0] < SPAN) && (len == 10'd0) && (size == 3'b110);
  endfunction

  logic [511:0] mem [DEPTH_LINES];
  logic         live;
  rd_state_t    rd_state, rd_next;
  wr_state_t    wr_state, wr_next;
  logic [3:0]   lat_cnt;
  logic [11:0]  rid_q, awid_q, bid_q;
  logic [1:0]   rresp_q, bresp_q;
  logic [511:0] rdata_q, wdata_q;
  logic         aw_held, w_held;
  logic [63:0]  awaddr_q, wstrb_q;
  logic [9:0]   awlen_q;
  logic [2:0]   awsize_q;
  logic         ar_fire, aw_fire, w_fire, commit, ar_legal, wr_legal;
  logic [64:0]  ar_diff, wr_diff;
  logic [11:0]  c_id;
  logic [63:0]  c_addr, c_strb;
  logic [9:0]   c_len;
  logic [2:0]   c_size;
  logic [511:0] c_data;
  logic         unused_ok;

  assign unused_ok = ^{aruser, awuser, arburst, wlast};

  assign ar_fire  = arvalid & arready;
  assign aw_fire  = awvalid & awready;
  assign w_fire   = wvalid & wready;
  assign ar_diff  = {1'b0, araddr} - {1'b0, BASE_ADDR};
  assign ar_legal = legal_req(ar_diff, arlen, arsize);

  // Commit uses whichever of AW/W is already latched, else the live channel
  assign c_id     = aw_held ? awid_q   : awid;
  assign c_addr   = aw_held ? awaddr_q : awaddr;
  assign c_len    = aw_held ? awlen_q  : awlen;
  assign c_size   = aw_held ? awsize_q : awsize;
  assign c_data   = w_held  ? wdata_q  : wdata;
  assign c_strb   = w_held  ? wstrb_q  : wstrb;
  assign wr_diff  = {1'b0, c_addr} - {1'b0, BASE_ADDR};
  assign wr_legal = legal_req(wr_diff, c_len, c_size);
  assign commit   = (wr_state == WR_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);

  // ---- state registers ----
  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      live     <= 1'b0;
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
      lat_cnt  <= '0;
    end else begin
      live     <= 1'b1;
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (ar_fire)                  lat_cnt <= 4'(READ_LAT - 1);
      else if (rd_state == RD_WAIT) lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_fire) rd_next = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (lat_cnt == 4'd1) rd_next = RD_RESP;
      RD_RESP: if (rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_next = WR_RESP;
      WR_RESP: if (bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (rd_state)
      RD_IDLE: arready = live;
      RD_RESP: begin
        rvalid = 1'b1;
        rlast  = 1'b1;
      end
      default: ;
    endcase
    case (wr_state)
      WR_IDLE: begin
        awready = live & ~aw_held;
        wready  = live & ~w_held;
      end
      WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  // ---- response payload registers ----
  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      rid_q   <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bid_q   <= '0;
      bresp_q <= '0;
    end else begin
      if (ar_fire) begin
        rid_q   <= arid;
        rresp_q <= ar_legal ? 2'b00 : 2'b10;
        rdata_q <= ar_legal ? mem[ar_diff[6 +: IW]] : '0;
      end
      if (aw_fire) aw_held <= 1'b1;
      if (w_fire)  w_held  <= 1'b1;
      if (commit) begin
        bid_q   <= c_id;
        bresp_q <= wr_legal ? 2'b00 : 2'b10;
      end
      if (wr_state == WR_RESP && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (aw_fire) begin
      awid_q   <= awid;
      awaddr_q <= awaddr;
      awlen_q  <= awlen;
      awsize_q <= awsize;
    end
    if (w_fire) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // ---- line storage (no reset; reset cycle never writes) ----
  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst && commit && wr_legal) begin
      for (int b = 0; b < 64; b++) begin
        if (c_strb[b]) mem[wr_diff[6 +: IW]][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  assign rid   = rid_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign ruser = 1'b0;
  assign bid   = bid_q;
  assign bresp = bresp_q;
  assign buser = '0;

`ifdef PREFETCH_RESP_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, err_cnt;
  logic        r_hs, b_hs;

  assign r_hs = rvalid & rready;
  assign b_hs = bvalid & bready;

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      rd_cnt  <= rd_cnt + 32'(r_hs);
      wr_cnt  <= wr_cnt + 32'(b_hs);
      err_cnt <= err_cnt + 32'(r_hs & (rresp_q == 2'b10)) + 32'(b_hs & (bresp_q == 2'b10));
    end
  end

  assign stat_rd_cnt  = rd_cnt;
  assign stat_wr_cnt  = wr_cnt;
  assign stat_err_cnt = err_cnt;
`else
  assign stat_rd_cnt  = '0;
  assign stat_wr_cnt  = '0;
  assign stat_err_cnt = '0;
`endif
endmodule

// File: tb/tb_prefetch_axi_responder.sv
// Randomized scoreboard bench for prefetch_axi_responder with a line-array reference model.
module tb_prefetch_axi_responder;
  localparam logic [63:0] BASE  = 64'h0000_0000_0004_0000;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 3;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd64;

  logic clk = 1'b0, rst = 1'b1;
  logic [11:0] arid = '0, awid = '0, rid, bid;
  logic [63:0] araddr = '0, awaddr = '0, wstrb = '0;
  logic [9:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = '0, awsize = '0;
  logic [1:0] arburst = '0, rresp, bresp;
  logic [5:0] aruser = '0, awuser = '0;
  logic arvalid = 0, arready, rlast, ruser, rvalid, rready = 0;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic [511:0] rdata, wdata = '0;
  logic [3:0] buser;
  logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;

  prefetch_axi_responder #(.BASE_ADDR(BASE), .DEPTH_LINES(DEPTH), .READ_LAT(LAT)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awuser(awuser),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] id; logic [511:0] data; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [11:0] id; logic [1:0] resp; } b_exp_t;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  logic [511:0] mem_m [DEPTH];
  int total = 0, bad = 0, cyc = 0, ar_cyc = 0, cm_cyc = 0;
  logic hold = 1'b1;
  logic aw_seen = 0, w_seen = 0, wr_busy = 0;
  logic [11:0] m_awid;
  logic [63:0] m_awaddr, m_wstrb;
  logic [9:0] m_awlen;
  logic [2:0] m_awsize;
  logic [511:0] m_wdata;
  logic [31:0] m_rd = 0, m_wr = 0, m_err = 0;
  logic rst_q = 1, rv_q = 0, rr_q = 0, bv_q = 0, br_q = 0;
  logic [11:0] p_rid, p_bid;
  logic [511:0] p_rdata;
  logic [1:0] p_rresp, p_bresp;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic legal(input logic [63:0] a, input logic [9:0] l, input logic [2:0] s);
    logic [63:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < SPAN) && (l == 0) && (s == 3'b110);
  endfunction

  function automatic int line_of(input logic [63:0] a);
    return int'((a - BASE) >> 6);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always begin
    @(posedge clk);
    #1;
    rready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    bready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor and reference model, both evaluated mid-cycle
  always @(negedge clk) begin : mon
    r_exp_t er;
    b_exp_t eb;
    cyc++;
    if (rst) begin
      if (rst_q) begin
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
      end
      exp_r.delete();
      exp_b.delete();
      aw_seen = 0; w_seen = 0; wr_busy = 0;
      m_rd = 0; m_wr = 0; m_err = 0;
    end else begin
      if (rvalid) begin
        check("r_no_arready", arready, 0);
        check("r_rlast_ruser", {rlast, ruser}, 2'b10);
        if (!rv_q) check("r_latency", 512'(cyc - ar_cyc), 512'(LAT));
        else if (!rr_q) check("r_stable", {p_rid, p_rresp, p_rdata}, {rid, rresp, rdata});
        check("r_pending", exp_r.size() != 0, 1);
        if (rready && exp_r.size() != 0) begin
          er = exp_r.pop_front();
          check("r_id", rid, er.id);
          check("r_resp", rresp, er.resp);
          check("r_data", rdata, er.data);
          m_rd++;
          if (er.resp == 2'b10) m_err++;
        end
      end
      if (bvalid) begin
        check("b_no_ready", {awready, wready}, 0);
        check("b_buser", buser, 0);
        if (!bv_q) check("b_latency", 512'(cyc - cm_cyc), 512'd1);
        else if (!br_q) check("b_stable", {p_bid, p_bresp}, {bid, bresp});
        check("b_pending", exp_b.size() != 0, 1);
        if (bready && exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          check("b_id", bid, eb.id);
          check("b_resp", bresp, eb.resp);
          m_wr++;
          if (eb.resp == 2'b10) m_err++;
          wr_busy = 0; aw_seen = 0; w_seen = 0;
        end
      end
      if (arvalid && arready) begin
        er.id   = arid;
        er.resp = legal(araddr, arlen, arsize) ? 2'b00 : 2'b10;
        er.data = (er.resp == 2'b00) ? mem_m[line_of(araddr)] : '0;
        exp_r.push_back(er);
        ar_cyc = cyc;
      end
      if (awvalid && awready) begin
        aw_seen = 1; m_awid = awid; m_awaddr = awaddr; m_awlen = awlen; m_awsize = awsize;
      end
      if (wvalid && wready) begin
        w_seen = 1; m_wdata = wdata; m_wstrb = wstrb;
      end
      if (!wr_busy && aw_seen && w_seen) begin
        eb.id   = m_awid;
        eb.resp = legal(m_awaddr, m_awlen, m_awsize) ? 2'b00 : 2'b10;
        if (eb.resp == 2'b00)
          for (int b = 0; b < 64; b++)
            if (m_wstrb[b]) mem_m[line_of(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
        exp_b.push_back(eb);
        wr_busy = 1;
        cm_cyc = cyc;
      end
    end
    rst_q = rst; rv_q = rvalid; rr_q = rready; bv_q = bvalid; br_q = bready;
    p_rid = rid; p_rdata = rdata; p_rresp = rresp; p_bid = bid; p_bresp = bresp;
  end

  task automatic send_ar(input logic [63:0] a, input logic [2:0] s, input logic [9:0] l);
    int n;
    n = 0;
    arid = 12'($urandom); araddr = a; arsize = s; arlen = l;
    arburst = 2'($urandom); aruser = 6'($urandom); arvalid = 1;
    @(negedge clk);
    while (!arready && n < 200) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic send_aw(input logic [63:0] a, input logic [2:0] s, input logic [9:0] l);
    int n;
    n = 0;
    awid = 12'($urandom); awaddr = a; awsize = s; awlen = l; awuser = 6'($urandom); awvalid = 1;
    @(negedge clk);
    while (!awready && n < 200) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic send_w(input logic [511:0] d, input logic [63:0] st);
    int n;
    n = 0;
    wdata = d; wstrb = st; wlast = 1'($urandom); wvalid = 1;
    @(negedge clk);
    while (!wready && n < 200) begin @(negedge clk); n++; end
    check("w_accept", wready, 1);
    @(posedge clk); #1;
    wvalid = 0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] d, input logic [63:0] st,
                          input logic [2:0] s);
    fork
      send_aw(a, s, 10'd0);
      send_w(d, st);
    join
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0 || wr_busy) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("idle_reached", n < 400, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] er);
`ifdef PREFETCH_RESP_STATS_EN
    check("stat_rd", stat_rd_cnt, rd);
    check("stat_wr", stat_wr_cnt, wr);
    check("stat_err", stat_err_cnt, er);
`else
    check("stat_tied", {stat_rd_cnt, stat_wr_cnt, stat_err_cnt, 32'(rd & 0), 32'(wr & 0), 32'(er & 0)},
          {96'd0, 96'd0});
`endif
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return BASE + 64'($urandom_range(0, DEPTH - 1)) * 64 + 64'($urandom_range(0, 63));
    else if (r == 8) return BASE + SPAN + 64'($urandom_range(0, 4095));
    else return BASE - 64 + 64'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [511:0] pat_a, pat_b, pat_c;
    pat_a = {16{32'hA5A5_0F0F}};
    pat_b = {16{32'h1234_BEEF}};
    pat_c = {16{32'hC0DE_7700}};
    repeat (4) @(posedge clk);
    #1 rst = 0; hold = 0;

    for (int i = 0; i < DEPTH; i++) do_write(BASE + 64'(i) * 64, rand512(), '1, 3'b110);
    wait_idle();

    // basic write then read, plus partial write with W leading AW by 3 cycles
    do_write(BASE + 64'h40, pat_a, '1, 3'b110);
    wait_idle();
    send_ar(BASE + 64'h40, 3'b110, 10'd0);
    wait_idle();
    fork
      send_w(pat_b, 64'h0000_0000_0000_FFFF);
      begin repeat (3) @(posedge clk); #1; send_aw(BASE + 64'h40, 3'b110, 10'd0); end
    join
    wait_idle();
    send_ar(BASE + 64'h7F, 3'b110, 10'd0);
    wait_idle();

    // error requests
    send_ar(BASE + SPAN, 3'b110, 10'd0);
    send_ar(BASE + 64'h80, 3'b101, 10'd0);
    send_ar(BASE + 64'h80, 3'b110, 10'd1);
    send_ar(BASE - 64, 3'b110, 10'd0);
    do_write(BASE + 64'h80, pat_c, '1, 3'b101);
    do_write(BASE + SPAN + 64'h40, pat_c, '1, 3'b110);
    wait_idle();
    send_ar(BASE + 64'h80, 3'b110, 10'd0);
    wait_idle();

    // same-line AR and write commit in the same cycle
    do_write(BASE + 64'hC0, pat_b, '1, 3'b110);
    wait_idle();
    send_w(pat_c, '1);
    fork
      send_aw(BASE + 64'hC0, 3'b110, 10'd0);
      send_ar(BASE + 64'hC0, 3'b110, 10'd0);
    join
    wait_idle();
    send_ar(BASE + 64'hC0, 3'b110, 10'd0);
    wait_idle();

    // backpressure on both response channels
    hold = 1;
    fork
      send_ar(BASE + 64'h140, 3'b110, 10'd0);
      do_write(BASE + 64'h100, rand512(), 64'($urandom) << 8, 3'b110);
    join
    repeat (10) @(posedge clk);
    #1 hold = 0;
    wait_idle();

    // randomized concurrent traffic
    fork
      for (int i = 0; i < 60; i++) begin
        send_ar(rand_addr(), ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b110,
                ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'd0);
      end
      for (int i = 0; i < 60; i++) begin
        logic [63:0] a;
        logic [511:0] d;
        logic [63:0] st;
        int g1, g2;
        a = rand_addr(); d = rand512(); st = {$urandom, $urandom};
        g1 = $urandom_range(0, 3); g2 = $urandom_range(0, 3);
        fork
          begin repeat (g1) @(posedge clk); #1; send_aw(a, ($urandom_range(0, 9) == 0) ? 3'b101 : 3'b110, 10'd0); end
          begin repeat (g2) @(posedge clk); #1; send_w(d, st); end
        join
      end
    join
    wait_idle();
    check_stats(m_rd, m_wr, m_err);

    // reset while read waits for latency and write waits for bready
    hold = 1;
    fork
      send_ar(BASE + 64'h40, 3'b110, 10'd0);
      do_write(BASE + 64'h180, pat_a, '1, 3'b110);
    join
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0; hold = 0;
    repeat (20) @(posedge clk);
    #1;
    check_stats(0, 0, 0);

    // a write presented during reset must not land
    rst = 1;
    awid = 12'h5; awaddr = BASE + 64'h180; awsize = 3'b110; awlen = 0; awvalid = 1;
    wdata = pat_c; wstrb = '1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    send_ar(BASE + 64'h180, 3'b110, 10'd0);
    do_write(BASE + 64'h1C0, pat_b, '1, 3'b110);
    wait_idle();
    check_stats(1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1);
  end
endmodule
